// File: rtl/mips_decode_execute.sv
// Registered decode/execute stage: main control decode, immediate extend, ALU-source mux, 32-bit ALU.
// Optional signed-overflow detection is built only when MIPS_ALU_OVERFLOW_EN is defined.
module mips_decode_execute (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] instruction,
    input  logic [31:0] read_data_1,
    input  logic [31:0] read_data_2,
    output logic        out_valid,
    output logic [6:0]  signals,
    output logic [2:0]  alu_op,
    output logic [31:0] imm_ext,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic        illegal,
    output logic        overflow
);

    localparam logic [2:0] AluAnd  = 3'b000;
    localparam logic [2:0] AluOr   = 3'b001;
    localparam logic [2:0] AluAdd  = 3'b010;
    localparam logic [2:0] AluSltu = 3'b011;
    localparam logic [2:0] AluNor  = 3'b100;
    localparam logic [2:0] AluXor  = 3'b101;
    localparam logic [2:0] AluSub  = 3'b110;
    localparam logic [2:0] AluSlt  = 3'b111;

    // signals bit order: {RegWrite, ALUSrc, MemWrite, MemtoReg, MemRead, Branch, RegDst}
    localparam logic [6:0] SigRType = 7'b1000001;
    localparam logic [6:0] SigIAlu  = 7'b1100000;
    localparam logic [6:0] SigLoad  = 7'b1101100;
    localparam logic [6:0] SigStore = 7'b0110000;
    localparam logic [6:0] SigBr    = 7'b0000010;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign op    = instruction[31:26];
    assign funct = instruction[5:0];
    assign imm   = instruction[15:0];

    // rs/rt indices are consumed by the register file, not here
    logic unused_fields;
    assign unused_fields = ^instruction[25:16];

    logic [6:0]  signals_d;
    logic [2:0]  alu_op_d;
    logic        zero_ext;
    logic        illegal_d;
    logic [31:0] imm_ext_d;
    logic [31:0] alu_b;
    logic [31:0] alu_result_d;
    logic        zero_d;
    logic        overflow_d;

    always_comb begin
        signals_d = 7'b0;
        alu_op_d  = AluAdd;
        zero_ext  = 1'b0;
        illegal_d = 1'b0;
        case (op)
            6'b000000: begin
                signals_d = SigRType;
                case (funct)
                    6'b100000, 6'b100001: alu_op_d = AluAdd;
                    6'b100010, 6'b100011: alu_op_d = AluSub;
                    6'b100100:            alu_op_d = AluAnd;
                    6'b100101:            alu_op_d = AluOr;
                    6'b100110:            alu_op_d = AluXor;
                    6'b100111:            alu_op_d = AluNor;
                    6'b101010:            alu_op_d = AluSlt;
                    6'b101011:            alu_op_d = AluSltu;
                    default: begin
                        signals_d = 7'b0;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            6'b001000, 6'b001001: signals_d = SigIAlu;
            6'b001010: begin
                signals_d = SigIAlu;
                alu_op_d  = AluSlt;
            end
            6'b001011: begin
                signals_d = SigIAlu;
                alu_op_d  = AluSltu;
            end
            6'b001100: begin
                signals_d = SigIAlu;
                alu_op_d  = AluAnd;
                zero_ext  = 1'b1;
            end
            6'b001101: begin
                signals_d = SigIAlu;
                alu_op_d  = AluOr;
                zero_ext  = 1'b1;
            end
            6'b001110: begin
                signals_d = SigIAlu;
                alu_op_d  = AluXor;
                zero_ext  = 1'b1;
            end
            6'b100011: signals_d = SigLoad;
            6'b101011: signals_d = SigStore;
            6'b000100, 6'b000101: begin
                signals_d = SigBr;
                alu_op_d  = AluSub;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    assign imm_ext_d = zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    assign alu_b     = signals_d[5] ? imm_ext_d : read_data_2;

    always_comb begin
        alu_result_d = 32'h0;
        case (alu_op_d)
            AluAnd:  alu_result_d = read_data_1 & alu_b;
            AluOr:   alu_result_d = read_data_1 | alu_b;
            AluAdd:  alu_result_d = read_data_1 + alu_b;
            AluSltu: alu_result_d = {31'h0, read_data_1 < alu_b};
            AluNor:  alu_result_d = ~(read_data_1 | alu_b);
            AluXor:  alu_result_d = read_data_1 ^ alu_b;
            AluSub:  alu_result_d = read_data_1 - alu_b;
            AluSlt:  alu_result_d = {31'h0, $signed(read_data_1) < $signed(alu_b)};
            default: alu_result_d = 32'h0;
        endcase
    end

    assign zero_d = (alu_result_d == 32'h0);

`ifdef MIPS_ALU_OVERFLOW_EN
    logic ovf_add;
    logic ovf_sub;

    // Only the trapping forms (add, sub, addi) report overflow
    always_comb begin
        ovf_add = 1'b0;
        ovf_sub = 1'b0;
        if (op == 6'b000000 && funct == 6'b100000) ovf_add = 1'b1;
        if (op == 6'b001000)                       ovf_add = 1'b1;
        if (op == 6'b000000 && funct == 6'b100010) ovf_sub = 1'b1;
    end

    assign overflow_d = (ovf_add & (read_data_1[31] == alu_b[31])
                                 & (alu_result_d[31] != read_data_1[31]))
                      | (ovf_sub & (read_data_1[31] != alu_b[31])
                                 & (alu_result_d[31] != read_data_1[31]));
`else
    assign overflow_d = 1'b0;
`endif

    logic        out_valid_q;
    logic [6:0]  signals_q;
    logic [2:0]  alu_op_q;
    logic [31:0] imm_ext_q;
    logic [31:0] alu_result_q;
    logic        zero_q;
    logic        illegal_q;
    logic        overflow_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            signals_q    <= 7'b0;
            alu_op_q     <= 3'b0;
            imm_ext_q    <= 32'h0;
            alu_result_q <= 32'h0;
            zero_q       <= 1'b0;
            illegal_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                signals_q    <= signals_d;
                alu_op_q     <= alu_op_d;
                imm_ext_q    <= imm_ext_d;
                alu_result_q <= alu_result_d;
                zero_q       <= zero_d;
                illegal_q    <= illegal_d;
                overflow_q   <= overflow_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign signals    = signals_q;
    assign alu_op     = alu_op_q;
    assign imm_ext    = imm_ext_q;
    assign alu_result = alu_result_q;
    assign zero       = zero_q;
    assign illegal    = illegal_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_mips_decode_execute.sv
// Table-driven bench for mips_decode_execute with an expected-output queue.
module tb_mips_decode_execute;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [31:0] instruction;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic        out_valid;
    logic [6:0]  signals;
    logic [2:0]  alu_op;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        zero;
    logic        illegal;
    logic        overflow;

    mips_decode_execute dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .instruction (instruction),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .out_valid   (out_valid),
        .signals     (signals),
        .alu_op      (alu_op),
        .imm_ext     (imm_ext),
        .alu_result  (alu_result),
        .zero        (zero),
        .illegal     (illegal),
        .overflow    (overflow)
    );

`ifdef MIPS_ALU_OVERFLOW_EN
    localparam logic OvfEn = 1'b1;
`else
    localparam logic OvfEn = 1'b0;
`endif

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [6:0]  sig;
        logic [2:0]  op;
        logic [31:0] ext;
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic        v;
        logic [6:0]  sig;
        logic [2:0]  op;
        logic [31:0] ext;
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic        ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t last;
    int   errors = 0;
    int   checks = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] ity(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    function automatic logic [31:0] rty(input logic [5:0] funct);
        return {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, funct};
    endfunction

    function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] a,
                                input logic [31:0] b, input logic [6:0] sig,
                                input logic [2:0] op, input logic [31:0] ext,
                                input logic [31:0] res, input logic z,
                                input logic ill, input logic ovf);
        vec_t t;
        t.ins = ins; t.a = a; t.b = b; t.sig = sig; t.op = op;
        t.ext = ext; t.res = res; t.z = z; t.ill = ill; t.ovf = ovf;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare(input exp_t e);
        chk("out_valid", {31'h0, out_valid}, {31'h0, e.v});
        chk("signals", {25'h0, signals}, {25'h0, e.sig});
        chk("alu_op", {29'h0, alu_op}, {29'h0, e.op});
        chk("imm_ext", imm_ext, e.ext);
        chk("alu_result", alu_result, e.res);
        chk("zero", {31'h0, zero}, {31'h0, e.z});
        chk("illegal", {31'h0, illegal}, {31'h0, e.ill});
        chk("overflow", {31'h0, overflow}, {31'h0, e.ovf & OvfEn});
    endtask

    task automatic check_reset_zeros(input string tag);
        chk({tag, " out_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, " signals"}, {25'h0, signals}, 32'h0);
        chk({tag, " alu_op"}, {29'h0, alu_op}, 32'h0);
        chk({tag, " imm_ext"}, imm_ext, 32'h0);
        chk({tag, " alu_result"}, alu_result, 32'h0);
        chk({tag, " zero"}, {31'h0, zero}, 32'h0);
        chk({tag, " illegal"}, {31'h0, illegal}, 32'h0);
        chk({tag, " overflow"}, {31'h0, overflow}, 32'h0);
    endtask

    // Each call compares the previous cycle's expectation, then drives this cycle
    task automatic step(input logic v, input vec_t t);
        exp_t e;
        @(negedge clock);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compare(e);
        end
        in_valid = v;
        if (v) begin
            instruction = t.ins;
            read_data_1 = t.a;
            read_data_2 = t.b;
            last.sig = t.sig; last.op = t.op; last.ext = t.ext; last.res = t.res;
            last.z = t.z; last.ill = t.ill; last.ovf = t.ovf;
        end else begin
            instruction = $urandom;
            read_data_1 = $urandom;
            read_data_2 = $urandom;
        end
        e   = last;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic clear_model();
        sb.delete();
        last.v = 1'b0; last.sig = '0; last.op = '0; last.ext = '0; last.res = '0;
        last.z = 1'b0; last.ill = 1'b0; last.ovf = 1'b0;
    endtask

    initial begin
        vec_t idle;
        idle = mk(32'h0, 32'h0, 32'h0, 7'h0, 3'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // instruction, A, B, signals, alu_op, imm_ext, alu_result, zero, illegal, overflow
        vecs.push_back(mk(ity(6'b001000, 16'hFFFF), 32'h5, 32'h9, 7'b1100000, 3'b010,
                          32'hFFFFFFFF, 32'h4, 0, 0, 0));
        vecs.push_back(mk(ity(6'b001100, 16'h8000), 32'hFFFFFFFF, 32'h0, 7'b1100000, 3'b000,
                          32'h00008000, 32'h00008000, 0, 0, 0));
        vecs.push_back(mk(ity(6'b000100, 16'h0010), 32'h1234, 32'h1234, 7'b0000010, 3'b110,
                          32'h00000010, 32'h0, 1, 0, 0));
        vecs.push_back(mk(ity(6'b000101, 16'hFFF0), 32'h1234, 32'h1235, 7'b0000010, 3'b110,
                          32'hFFFFFFF0, 32'hFFFFFFFF, 0, 0, 0));
        vecs.push_back(mk(ity(6'b100011, 16'hFFFC), 32'h100, 32'h7, 7'b1101100, 3'b010,
                          32'hFFFFFFFC, 32'hFC, 0, 0, 0));
        vecs.push_back(mk(ity(6'b101011, 16'hFFFC), 32'h100, 32'h7, 7'b0110000, 3'b010,
                          32'hFFFFFFFC, 32'hFC, 0, 0, 0));
        vecs.push_back(mk(rty(6'b101010), 32'hFFFFFFFF, 32'h1, 7'b1000001, 3'b111,
                          32'h0000182A, 32'h1, 0, 0, 0));
        vecs.push_back(mk(rty(6'b101011), 32'hFFFFFFFF, 32'h1, 7'b1000001, 3'b011,
                          32'h0000182B, 32'h0, 1, 0, 0));
        vecs.push_back(mk(rty(6'b000000), 32'h3, 32'h4, 7'b0000000, 3'b010,
                          32'h00001800, 32'h7, 0, 1, 0));
        vecs.push_back(mk(rty(6'b100000), 32'h7FFFFFFF, 32'h1, 7'b1000001, 3'b010,
                          32'h00001820, 32'h80000000, 0, 0, 1));
        vecs.push_back(mk(rty(6'b100001), 32'h7FFFFFFF, 32'h1, 7'b1000001, 3'b010,
                          32'h00001821, 32'h80000000, 0, 0, 0));
        vecs.push_back(mk(rty(6'b100010), 32'h80000000, 32'h1, 7'b1000001, 3'b110,
                          32'h00001822, 32'h7FFFFFFF, 0, 0, 1));
        vecs.push_back(mk(rty(6'b100011), 32'h5, 32'h5, 7'b1000001, 3'b110,
                          32'h00001823, 32'h0, 1, 0, 0));
        vecs.push_back(mk(rty(6'b100100), 32'hF0F0F0F0, 32'hFF00FF00, 7'b1000001, 3'b000,
                          32'h00001824, 32'hF000F000, 0, 0, 0));
        vecs.push_back(mk(rty(6'b100101), 32'hF0F0F0F0, 32'hFF00FF00, 7'b1000001, 3'b001,
                          32'h00001825, 32'hFFF0FFF0, 0, 0, 0));
        vecs.push_back(mk(rty(6'b100110), 32'hF0F0F0F0, 32'hFF00FF00, 7'b1000001, 3'b101,
                          32'h00001826, 32'h0FF00FF0, 0, 0, 0));
        vecs.push_back(mk(rty(6'b100111), 32'hF0F0F0F0, 32'hFF00FF00, 7'b1000001, 3'b100,
                          32'h00001827, 32'h000F000F, 0, 0, 0));
        vecs.push_back(mk(ity(6'b001010, 16'hFFFF), 32'h1, 32'h0, 7'b1100000, 3'b111,
                          32'hFFFFFFFF, 32'h0, 1, 0, 0));
        vecs.push_back(mk(ity(6'b001011, 16'hFFFF), 32'h1, 32'h0, 7'b1100000, 3'b011,
                          32'hFFFFFFFF, 32'h1, 0, 0, 0));
        vecs.push_back(mk(ity(6'b001101, 16'h8001), 32'h12340000, 32'h0, 7'b1100000, 3'b001,
                          32'h00008001, 32'h12348001, 0, 0, 0));
        vecs.push_back(mk(ity(6'b001110, 16'h8001), 32'h0000FFFF, 32'h0, 7'b1100000, 3'b101,
                          32'h00008001, 32'h00007FFE, 0, 0, 0));
        vecs.push_back(mk(ity(6'b001001, 16'h0001), 32'h7FFFFFFF, 32'h0, 7'b1100000, 3'b010,
                          32'h00000001, 32'h80000000, 0, 0, 0));
        vecs.push_back(mk(ity(6'b001000, 16'h0001), 32'h7FFFFFFF, 32'h0, 7'b1100000, 3'b010,
                          32'h00000001, 32'h80000000, 0, 0, 1));
        vecs.push_back(mk(ity(6'b111111, 16'h8000), 32'h1, 32'h2, 7'b0000000, 3'b010,
                          32'hFFFF8000, 32'h3, 0, 1, 0));

        // Reset held with random inputs: outputs must be zero before any clock edge
        reset       = 1'b0;
        in_valid    = 1'b1;
        instruction = $urandom;
        read_data_1 = $urandom;
        read_data_2 = $urandom;
        clear_model();
        #2;
        check_reset_zeros("reset");
        @(negedge clock);
        reset = 1'b1;

        // Table, back to back
        foreach (vecs[i]) step(1'b1, vecs[i]);

        // Idle cycles: data must hold, out_valid drops
        step(1'b0, idle);
        step(1'b0, idle);
        step(1'b1, vecs[0]);
        step(1'b0, idle);
        step(1'b1, vecs[9]);

        // Asynchronous reset mid-stream, then release with valid input pending
        step(1'b1, vecs[11]);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_reset_zeros("midreset");
        clear_model();
        #1;
        reset = 1'b1;
        step(1'b1, vecs[4]);
        step(1'b1, vecs[2]);
        step(1'b0, idle);
        step(1'b0, idle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_decode_execute.md
# mips_decode_execute

Registered decode/execute stage for the single-cycle MIPS core, combining the main control decoder, the 16→32-bit immediate extender, the ALU-source mux and the 32-bit ALU. It sits between the register file (which supplies `read_data_1`/`read_data_2`) and the data-memory/write-back logic. One instruction is accepted per clock, and all results are registered with one-cycle latency.

## Interface
One clock; reset is asynchronous and active-low (ports `clock`, `reset`).

Parameters: none.

Ports:
- `clock` in 1 — rising-edge clock.
- `reset` in 1 — asynchronous, active-low; clears all output registers.
- `in_valid` in 1 — `instruction` and operands are valid this cycle.
- `instruction` in 32 — fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], shmt[10:6], funct[5:0], imm[15:0].
- `read_data_1` in 32 — rs operand, ALU input A.
- `read_data_2` in 32 — rt operand, ALU input B when ALUSrc=0.
- `out_valid` out 1 — registered `in_valid`.
- `signals` out 7 — control bits: [0] RegDst, [1] Branch, [2] MemRead, [3] MemtoReg, [4] MemWrite, [5] ALUSrc, [6] RegWrite.
- `alu_op` out 3 — ALU operation applied.
- `imm_ext` out 32 — extended immediate.
- `alu_result` out 32 — ALU result.
- `zero` out 1 — `alu_result == 0`.
- `illegal` out 1 — opcode/funct not supported.
- `overflow` out 1 — signed overflow (see Configuration).

## Operation
Decode table (signals bits 6..0, alu_op, extension):
- R-type (op 000000): `signals` = 1000001. The ALU operation comes from funct: 100000/100001 → ADD 010; 100010/100011 → SUB 110; 100100 → AND 000; 100101 → OR 001; 100110 → XOR 101; 100111 → NOR 100; 101010 → SLT 111; 101011 → SLTU 011.
- addi 001000, addiu 001001: `signals` = 1100000, ADD, sign-extend.
- slti 001010: `signals` = 1100000, SLT, sign-extend. sltiu 001011: same but SLTU.
- andi 001100: AND, zero-extend. ori 001101: OR, zero-extend. xori 001110: XOR, zero-extend. All three use `signals` = 1100000.
- lw 100011: `signals` = 1101100, ADD, sign-extend.
- sw 101011: `signals` = 0110000, ADD, sign-extend.
- beq 000100, bne 000101: `signals` = 0000010, SUB, sign-extend; ALUSrc=0.
- Any other opcode or unlisted R-type funct: `signals` = 0000000, alu_op = ADD 010, `illegal` = 1, sign-extend.

Datapath:
- Extender: sign mode replicates imm[15]; zero mode fills with 0.
- ALU B operand = `imm_ext` when ALUSrc=1, else `read_data_2`.
- Arithmetic is modulo 2^32.
- SLT compares as signed and SLTU as unsigned; the result is 32'd1 or 32'd0.
- NOR = ~(A|B).
- `shmt` is ignored; no shift ops are supported.

## Timing
- All outputs are registered on the rising edge of `clock` when `in_valid` = 1, so latency is 1 cycle.
- When `in_valid` = 0, data outputs hold their previous values and `out_valid` = 0 on the next edge.
- Reset asserted (`reset` = 0): every output goes to 0 immediately, independent of `clock`. This includes `out_valid`, `signals`, `alu_op`, `imm_ext`, `alu_result`, `illegal` and `overflow`; `zero` also reads 0 during reset.
- Reset deasserting mid-stream: the first capture occurs on the first rising edge with `reset` = 1.
- Back-to-back `in_valid` is allowed; there is no backpressure.

## Configuration
- `MIPS_ALU_OVERFLOW_EN` defined: `overflow` = signed overflow for ADD/SUB when funct is 100000/100010 or op is addi. It is computed as operand signs equal (ADD) or differing (SUB) and the result sign differing from A, and is registered with the other outputs.
- Not defined: `overflow` is tied to 0 and no overflow logic is built.
- All other behaviour is identical in both builds.

## Test plan
- Reset: drive `reset` = 0 with random inputs → all outputs read 0 without a clock edge. Release reset, then send addi $rs=5, imm 0xFFFF → the next cycle gives `alu_result` = 4, `imm_ext` = 0xFFFFFFFF, `signals` = 1100000.
- Zero extension: andi with `read_data_1` = 0xFFFFFFFF, imm 0x8000 → `imm_ext` = 0x00008000, `alu_result` = 0x00008000, `zero` = 0.
- beq with `read_data_1` = `read_data_2` = 0x1234 → `alu_op` = 110, `zero` = 1, `signals` = 0000010. With unequal operands → `zero` = 0.
- lw and sw with `read_data_1` = 0x100, imm 0xFFFC → `alu_result` = 0xFC; `signals` = 1101100 (lw) and 0110000 (sw).
- R-type coverage: SLT with A = 0xFFFFFFFF, B = 1 → 1; SLTU with the same operands → 0. funct 000000 → `illegal` = 1, `signals` = 0.
- With `MIPS_ALU_OVERFLOW_EN` defined: add 0x7FFFFFFF + 1 → `alu_result` = 0x80000000, `overflow` = 1. addu with the same operands → `overflow` = 0.
